// File: rtl/max7219_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | max7219_rx : receive-side model of the MAX7219 DIN/CLK/LOAD interface      |
// |              with register file, Code-B decode and display gating.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module max7219_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_clk,
  input  logic       ser_din,
  input  logic       ser_cs,
  input  logic [2:0] rd_digit,
  output logic [7:0] rd_seg,
  output logic [7:0] decode_mode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       shutdown,
  output logic       display_test,
  output logic       word_valid,
  output logic [15:0] word_data,
  output logic       frame_err
);

  localparam logic [4:0] c_cnt_max  = 5'd31;
  localparam logic [4:0] c_word_len = 5'd16;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_cs_sync, r_din_sync;
  logic                   r_clk_d, r_cs_d;
  logic [15:0]            r_shreg;
  logic [4:0]             r_bit_cnt;
  logic [7:0]             r_digit [8];
  logic [7:0]             r_decode;
  logic [3:0]             r_intensity;
  logic [2:0]             r_scan;
  logic                   r_shutdown, r_test;
  logic                   r_word_valid, r_frame_err;
  logic [15:0]            r_word_data;

  logic       w_clk_s, w_cs_s, w_din_s;
  logic       w_clk_rise, w_cs_rise, w_cs_fall;
  logic [3:0] w_addr;
  logic [2:0] w_dig_idx;
  logic [7:0] w_sel;

  assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_din_s    = r_din_sync[SYNC_STAGES-1];
  assign w_clk_rise = w_clk_s & ~r_clk_d;
  assign w_cs_rise  = w_cs_s & ~r_cs_d;
  assign w_cs_fall  = ~w_cs_s & r_cs_d;
  assign w_addr     = r_shreg[11:8];
  assign w_dig_idx  = 3'(w_addr - 4'd1);

  // Idle level of CS and CLK is high, so their synchronizers reset high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clk_sync <= '1;
      r_cs_sync  <= '1;
      r_din_sync <= '0;
      r_clk_d    <= 1'b1;
      r_cs_d     <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ser_clk};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], ser_cs};
      r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], ser_din};
      r_clk_d    <= w_clk_s;
      r_cs_d     <= w_cs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      for (int i = 0; i < 8; i++) r_digit[i] <= '0;
      r_decode     <= '0;
      r_intensity  <= '0;
      r_scan       <= '0;
      r_shutdown   <= 1'b1;
      r_test       <= 1'b0;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_word_data  <= '0;
    end else begin
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_cs_rise) begin
        // A serial clock edge in the same cycle as CS rise is dropped.
        if (r_bit_cnt >= c_word_len) begin
          r_word_valid <= 1'b1;
          r_word_data  <= r_shreg;
          case (w_addr)
            4'h1, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8: r_digit[w_dig_idx] <= r_shreg[7:0];
            4'h9:    r_decode    <= r_shreg[7:0];
            4'hA:    r_intensity <= r_shreg[3:0];
            4'hB:    r_scan      <= r_shreg[2:0];
            4'hC:    r_shutdown  <= ~r_shreg[0];
            4'hF:    r_test      <= r_shreg[0];
            default: ;
          endcase
        end else begin
          r_frame_err <= 1'b1;
        end
      end else if (w_cs_fall) begin
        r_bit_cnt <= '0;
      end else if (w_clk_rise && !w_cs_s) begin
        r_shreg <= {r_shreg[14:0], w_din_s};
        if (r_bit_cnt != c_cnt_max) r_bit_cnt <= r_bit_cnt + 5'd1;
      end
    end
  end

  function automatic logic [6:0] codeb(input logic [3:0] v);
    case (v)
      4'h0: codeb = 7'h7E;  4'h1: codeb = 7'h30;
      4'h2: codeb = 7'h6D;  4'h3: codeb = 7'h79;
      4'h4: codeb = 7'h33;  4'h5: codeb = 7'h5B;
      4'h6: codeb = 7'h5F;  4'h7: codeb = 7'h70;
      4'h8: codeb = 7'h7F;  4'h9: codeb = 7'h7B;
      4'hA: codeb = 7'h01;  4'hB: codeb = 7'h4F;
      4'hC: codeb = 7'h37;  4'hD: codeb = 7'h0E;
      4'hE: codeb = 7'h67;  default: codeb = 7'h00;
    endcase
  endfunction

  assign w_sel = r_digit[rd_digit];

  always_comb begin
    rd_seg = w_sel;
    if (r_test)                    rd_seg = 8'hFF;
    else if (r_shutdown)           rd_seg = 8'h00;
    else if (rd_digit > r_scan)    rd_seg = 8'h00;
    else if (r_decode[rd_digit])   rd_seg = {w_sel[7], codeb(w_sel[3:0])};
  end

  assign decode_mode  = r_decode;
  assign intensity    = r_intensity;
  assign scan_limit   = r_scan;
  assign shutdown     = r_shutdown;
  assign display_test = r_test;
  assign word_valid   = r_word_valid;
  assign word_data    = r_word_data;
  assign frame_err    = r_frame_err;

endmodule
`default_nettype wire
